instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/cpu_pkg.sv | 39 +++
 rtl/instr_len_decode.sv | 9 +
 rtl/instr_fetch.sv | 85 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, register codes, fetch FSM states
// and the instruction length rule used by the fetch stage.
package cpu_pkg;

  localparam logic [7:0] OP_ADD     = 8'h00;
  localparam logic [7:0] OP_MUL     = 8'h10;
  localparam logic [7:0] OP_MOV     = 8'h20;
  localparam logic [7:0] OP_DIV_REG = 8'h30;
  localparam logic [7:0] OP_LD_IMM  = 8'h80;
  localparam logic [7:0] OP_INC     = 8'h84;
  localparam logic [7:0] OP_DEC     = 8'h88;
  localparam logic [7:0] OP_CMP_IMM = 8'h8C;
  localparam logic [7:0] OP_INPUT   = 8'h98;
  localparam logic [7:0] OP_OUTPUT  = 8'h9C;
  localparam logic [7:0] OP_BRA     = 8'hA0;
  localparam logic [7:0] OP_BHI     = 8'hA8;
  localparam logic [7:0] OP_BEQ     = 8'hB0;
  localparam logic [7:0] OP_NOP     = 8'hFF;

  localparam logic [1:0] R0 = 2'd0;
  localparam logic [1:0] R1 = 2'd1;
  localparam logic [1:0] R2 = 2'd2;
  localparam logic [1:0] R3 = 2'd3;

  typedef enum logic [1:0] {FETCH0 = 2'd0, FETCH1 = 2'd1, HOLD = 2'd2} fetch_state_t;

  typedef struct packed {
    logic [7:0] byte0;
    logic [7:0] byte1;
    logic       len2;
    logic [7:0] pc;
  } instr_t;

  // Branches, LD_IMM and CMP_IMM carry an immediate byte; everything else is one byte.
  function automatic logic is_len2(input logic [7:0] b0);
    return (b0[7:5] == 3'b101) || (b0[7:2] == 6'b100000) || (b0[7:2] == 6'b100011);
  endfunction

endpackage

// File: rtl/instr_len_decode.sv
// Combinational instruction length decode from the opcode byte.
module instr_len_decode
  import cpu_pkg::*;
(
  input  logic [7:0] i_byte0,
  output logic       o_len2
);
  assign o_len2 = is_len2(i_byte0);
endmodule

// File: rtl/instr_fetch.sv
// Byte-serial instruction fetch with a one-entry output hold register.
// Optional INSTR_FETCH_PREFETCH_EN overlaps the next opcode fetch with the handshake.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] address_bus,
  input  logic [7:0] data_bus,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [7:0] instr_byte0,
  output logic [7:0] instr_byte1,
  output logic       instr_len2,
  output logic [7:0] instr_pc,
  input  logic       redirect,
  input  logic [7:0] redirect_addr
);

  fetch_state_t r_state, w_state_nxt;
  logic [7:0]   r_pc, w_pc_nxt;
  instr_t       r_instr, w_instr_nxt;
  logic         w_len2, w_fire, w_cap0;

  instr_len_decode u_len (
    .i_byte0 (data_bus),
    .o_len2  (w_len2)
  );

  assign w_fire = (r_state == HOLD) && instr_ready;

`ifdef INSTR_FETCH_PREFETCH_EN
  assign w_cap0 = (r_state == FETCH0) || w_fire;
`else
  assign w_cap0 = (r_state == FETCH0);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    // Redirect wins over everything; a partial instruction is simply abandoned.
    if (redirect) begin
      w_pc_nxt    = redirect_addr;
      w_state_nxt = FETCH0;
    end else if (w_cap0) begin
      w_instr_nxt.byte0 = data_bus;
      w_instr_nxt.byte1 = 8'h00;
      w_instr_nxt.len2  = w_len2;
      w_instr_nxt.pc    = r_pc;
      w_pc_nxt          = r_pc + 8'd1;
      w_state_nxt       = w_len2 ? FETCH1 : HOLD;
    end else if (r_state == FETCH1) begin
      w_instr_nxt.byte1 = data_bus;
      w_pc_nxt          = r_pc + 8'd1;
      w_state_nxt       = HOLD;
    end else if (w_fire) begin
      w_state_nxt = FETCH0;
    end else if (r_state != HOLD) begin
      w_state_nxt = FETCH0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH0;
      r_pc    <= RESET_PC;
      r_instr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
    end
  end

  assign address_bus = r_pc;
  assign instr_valid = (r_state == HOLD);
  assign instr_byte0 = r_instr.byte0;
  assign instr_byte1 = r_instr.byte1;
  assign instr_len2  = r_instr.len2;
  assign instr_pc    = r_instr.pc;

endmodule
